// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// Package: mem_arb_pkg
// Purpose: Shared constants and the FSM state type for the unified-memory
//          arbiter (mem_arbiter) and its read-latency tag pipe.
// Contents:
//   BLOCK_WORDS      words per cache block (8)
//   WORD_IDX_W       width of a word index within a block (3)
//   BLOCK_OFF_W      byte-offset width of a block (4, i.e. 16-byte blocks)
//   MEM_LATENCY_DEF  default cycles from read issue to read data (4)
//   state_e          arbiter FSM states ST_IDLE, ST_WRITE, ST_FILL_I, ST_FILL_D
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int BLOCK_WORDS     = 8;
  localparam int WORD_IDX_W      = 3;
  localparam int BLOCK_OFF_W     = 4;
  localparam int MEM_LATENCY_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_FILL_I = 2'd2,
    ST_FILL_D = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arb_lat_pipe.sv
// ----------------------------------------------------------------------------
// Module: mem_arb_lat_pipe
// Purpose: Shift register that follows every issued memory read through the
//          memory's fixed latency, so the arbiter knows exactly which cycle a
//          read's data is on mem_data_out. Clearing it on reset guarantees that
//          reads in flight at reset time never surface as fill data.
// Parameters:
//   DEPTH  memory read latency in cycles (must be >= 2)
// Ports:
//   clk    in  clock
//   rst_n  in  async active-low reset, empties the pipe
//   issue  in  a read is being presented to the memory this cycle
//   ret    out the read issued DEPTH cycles ago has its data available now
// ----------------------------------------------------------------------------
module mem_arb_lat_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = MEM_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic ret
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d = {pipe_q[DEPTH-2:0], issue};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign ret = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// Module: mem_arbiter
// Purpose: Shares one single-port pipelined memory between the I-cache fill
//          path, the D-cache fill path and D-side write-through stores.
//          A fill issues the 8 reads of a block on consecutive cycles and hands
//          the returning words to the requester with their word index.
//          Grants are only made from IDLE; stores have absolute priority.
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> I and D fills alternate on a tie (D first
//                               after reset); stores still win outright.
//                  undefined -> fixed priority: store, D fill, I fill.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ic_miss / ic_addr               I-cache fill request (level) and address
//   ic_fill_vld/_idx/_data          I fill word strobe, word index, word
//   ic_done                         pulse with the last I fill word
//   ic_busy                         I request pending or in service
//   dc_miss / dc_addr / dc_fill_* / dc_done / dc_busy   D-side equivalents
//   dc_wr_req/_addr/_data           write-through store request (level)
//   dc_wr_ack                       pulse in the cycle the store is issued
//   mem_en, mem_wr, mem_addr, mem_data_in   memory command (mem_wr=1: write)
//   mem_data_out                    memory read data, MEM_LATENCY after issue
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_miss,
  input  logic [ADDR_W-1:0]     ic_addr,
  output logic                  ic_fill_vld,
  output logic [WORD_IDX_W-1:0] ic_fill_idx,
  output logic [DATA_W-1:0]     ic_fill_data,
  output logic                  ic_done,
  output logic                  ic_busy,
  input  logic                  dc_miss,
  input  logic [ADDR_W-1:0]     dc_addr,
  output logic                  dc_fill_vld,
  output logic [WORD_IDX_W-1:0] dc_fill_idx,
  output logic [DATA_W-1:0]     dc_fill_data,
  output logic                  dc_done,
  output logic                  dc_busy,
  input  logic                  dc_wr_req,
  input  logic [ADDR_W-1:0]     dc_wr_addr,
  input  logic [DATA_W-1:0]     dc_wr_data,
  output logic                  dc_wr_ack,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data_in,
  input  logic [DATA_W-1:0]     mem_data_out
);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [WORD_IDX_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [WORD_IDX_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_data_in_q, mem_data_in_d;
  logic                    wr_ack_q, wr_ack_d;
  logic                    ic_busy_q, ic_busy_d;
  logic                    dc_busy_q, dc_busy_d;

  logic                    pick_d, pick_i;
  logic [ADDR_W-1:0]       sel_addr;
  logic                    issue_tag, ret_strobe;
  logic                    fill_active, ret_vld, last_ret;
  logic                    unused_addr_bits;

  // The low block-offset bits of a miss address never matter: fills always
  // start at the block base.
  assign unused_addr_bits = ^{ic_addr[BLOCK_OFF_W-1:0], dc_addr[BLOCK_OFF_W-1:0]};

  // Only reads are tracked through the latency pipe; store cycles never
  // produce return data.
  assign issue_tag = mem_en_q & ~mem_wr_q;

  mem_arb_lat_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_lat_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .issue (issue_tag),
    .ret   (ret_strobe)
  );

  assign fill_active = (state_q == ST_FILL_I) || (state_q == ST_FILL_D);
  assign ret_vld     = ret_strobe && fill_active;
  assign last_ret    = ret_vld && (ret_cnt_q == '1);

`ifdef MEM_ARB_RR_EN
  logic rr_last_i_q, rr_last_i_d;

  // On a tie the fill side served last loses; the pointer starts at
  // "I last served" so D wins the first tie after reset.
  always_comb begin
    pick_d      = dc_miss && (!ic_miss || rr_last_i_q);
    rr_last_i_d = rr_last_i_q;
    if ((state_q == ST_IDLE) && !dc_wr_req && (dc_miss || ic_miss)) begin
      rr_last_i_d = !pick_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_i_q <= 1'b1;
    end else begin
      rr_last_i_q <= rr_last_i_d;
    end
  end
`else
  assign pick_d = dc_miss;
`endif

  assign pick_i   = ic_miss && !pick_d;
  assign sel_addr = pick_d ? dc_addr : ic_addr;

  // Next-state logic. Every memory command is registered, so the command
  // decided here appears on the memory port in the following cycle. The
  // grant cycle already issues word 0; issue_cnt then holds the next word to
  // issue and wrapping back to 0 marks the end of the issue phase.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    issue_cnt_d   = issue_cnt_q;
    ret_cnt_d     = ret_cnt_q;
    mem_en_d      = 1'b0;
    mem_wr_d      = 1'b0;
    mem_addr_d    = '0;
    mem_data_in_d = '0;
    wr_ack_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dc_wr_req) begin
          state_d       = ST_WRITE;
          mem_en_d      = 1'b1;
          mem_wr_d      = 1'b1;
          mem_addr_d    = dc_wr_addr;
          mem_data_in_d = dc_wr_data;
          wr_ack_d      = 1'b1;
        end else if (pick_d || pick_i) begin
          state_d     = pick_d ? ST_FILL_D : ST_FILL_I;
          base_d      = {sel_addr[ADDR_W-1:BLOCK_OFF_W], {BLOCK_OFF_W{1'b0}}};
          mem_en_d    = 1'b1;
          mem_addr_d  = {sel_addr[ADDR_W-1:BLOCK_OFF_W], {BLOCK_OFF_W{1'b0}}};
          issue_cnt_d = WORD_IDX_W'(1);
          ret_cnt_d   = '0;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_FILL_I, ST_FILL_D: begin
        if (issue_cnt_q != '0) begin
          mem_en_d    = 1'b1;
          mem_addr_d  = {base_q[ADDR_W-1:BLOCK_OFF_W], issue_cnt_q, 1'b0};
          issue_cnt_d = issue_cnt_q + WORD_IDX_W'(1);
        end
        if (ret_vld) begin
          ret_cnt_d = ret_cnt_q + WORD_IDX_W'(1);
        end
        if (last_ret) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Busy covers both a request still waiting for a grant and a grant in
  // service; it drops once the requester's done has been delivered.
  always_comb begin
    ic_busy_d = (state_d == ST_FILL_I) || (ic_miss && !ic_done);
    dc_busy_d = (state_d == ST_FILL_D) || (state_d == ST_WRITE) ||
                (dc_miss && !dc_done) || dc_wr_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      issue_cnt_q   <= '0;
      ret_cnt_q     <= '0;
      mem_en_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      wr_ack_q      <= 1'b0;
      ic_busy_q     <= 1'b0;
      dc_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      issue_cnt_q   <= issue_cnt_d;
      ret_cnt_q     <= ret_cnt_d;
      mem_en_q      <= mem_en_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      wr_ack_q      <= wr_ack_d;
      ic_busy_q     <= ic_busy_d;
      dc_busy_q     <= dc_busy_d;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign dc_wr_ack   = wr_ack_q;
  assign ic_busy     = ic_busy_q;
  assign dc_busy     = dc_busy_q;

  // Fill data is passed straight from the memory in its return cycle and
  // forced to zero otherwise so idle cycles never leak stale read data.
  assign ic_fill_vld  = ret_vld && (state_q == ST_FILL_I);
  assign dc_fill_vld  = ret_vld && (state_q == ST_FILL_D);
  assign ic_fill_idx  = ic_fill_vld ? ret_cnt_q : '0;
  assign dc_fill_idx  = dc_fill_vld ? ret_cnt_q : '0;
  assign ic_fill_data = ic_fill_vld ? mem_data_out : '0;
  assign dc_fill_data = dc_fill_vld ? mem_data_out : '0;
  assign ic_done      = last_ret && (state_q == ST_FILL_I);
  assign dc_done      = last_ret && (state_q == ST_FILL_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench: tb_mem_arbiter
// Purpose: Directed and random stimulus for mem_arbiter against a pipelined
//          reference memory. Expected fill words and read addresses are queued
//          when a request is raised and compared as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;

  typedef struct packed {
    logic          side_d;
    logic [2:0]    idx;
    logic [DW-1:0] data;
  } ret_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_miss, dc_miss, dc_wr_req;
  logic [AW-1:0] ic_addr, dc_addr, dc_wr_addr;
  logic [DW-1:0] dc_wr_data;
  logic          ic_fill_vld, dc_fill_vld, ic_done, dc_done, ic_busy, dc_busy;
  logic [2:0]    ic_fill_idx, dc_fill_idx;
  logic [DW-1:0] ic_fill_data, dc_fill_data;
  logic          dc_wr_ack, mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;

  int   checks = 0;
  int   errors = 0;
  ret_t          exp_ret_q[$];
  logic [AW-1:0] exp_addr_q[$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ic_miss      (ic_miss),
    .ic_addr      (ic_addr),
    .ic_fill_vld  (ic_fill_vld),
    .ic_fill_idx  (ic_fill_idx),
    .ic_fill_data (ic_fill_data),
    .ic_done      (ic_done),
    .ic_busy      (ic_busy),
    .dc_miss      (dc_miss),
    .dc_addr      (dc_addr),
    .dc_fill_vld  (dc_fill_vld),
    .dc_fill_idx  (dc_fill_idx),
    .dc_fill_data (dc_fill_data),
    .dc_done      (dc_done),
    .dc_busy      (dc_busy),
    .dc_wr_req    (dc_wr_req),
    .dc_wr_addr   (dc_wr_addr),
    .dc_wr_data   (dc_wr_data),
    .dc_wr_ack    (dc_wr_ack),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Reference memory: word-addressed by byte address [15:1], read data
  // appears LAT cycles after the read is presented; not reset by rst_n.
  logic [DW-1:0] ref_mem [0:32767];
  logic [AW-1:0] rd_addr_pipe [LAT];
  logic          rd_vld_pipe  [LAT];

  always @(posedge clk) begin
    if (mem_en && mem_wr) ref_mem[mem_addr[AW-1:1]] <= mem_data_in;
    rd_vld_pipe[0]  <= mem_en && !mem_wr;
    rd_addr_pipe[0] <= mem_addr;
    for (int i = 1; i < LAT; i++) begin
      rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
      rd_addr_pipe[i] <= rd_addr_pipe[i-1];
    end
  end

  assign mem_data_out = rd_vld_pipe[LAT-1] ? ref_mem[rd_addr_pipe[LAT-1][AW-1:1]] : 16'hDEAD;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the 8 reads and 8 returned words of a block fill.
  task automatic push_fill(input logic side_d, input logic [AW-1:0] addr);
    logic [AW-1:0] a;
    ret_t e;
    for (int k = 0; k < 8; k++) begin
      a = {addr[AW-1:4], 4'h0} + AW'(2 * k);
      exp_addr_q.push_back(a);
      e.side_d = side_d;
      e.idx    = k[2:0];
      e.data   = ref_mem[a[AW-1:1]];
      exp_ret_q.push_back(e);
    end
  endtask

  task automatic wait_done(input logic side_d, input string tag);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(side_d ? dc_done : ic_done) && cyc < 60);
    check_output(tag, side_d ? dc_done : ic_done, 1);
  endtask

  // Monitor: every read issue and every returned word is matched against
  // the scoreboard queues.
  always @(negedge clk) begin
    ret_t e;
    if (rst_n === 1'b1) begin
      if (mem_en && !mem_wr) begin
        check_output("read_expected", (exp_addr_q.size() > 0) ? 1 : 0, 1);
        if (exp_addr_q.size() > 0) check_output("read_addr", mem_addr, exp_addr_q.pop_front());
      end
      check_output("one_side_vld", ic_fill_vld && dc_fill_vld, 0);
      if (ic_fill_vld || dc_fill_vld) begin
        check_output("ret_expected", (exp_ret_q.size() > 0) ? 1 : 0, 1);
        if (exp_ret_q.size() > 0) begin
          e = exp_ret_q.pop_front();
          check_output("ret_side", dc_fill_vld, e.side_d);
          check_output("ret_idx", dc_fill_vld ? dc_fill_idx : ic_fill_idx, e.idx);
          check_output("ret_data", dc_fill_vld ? dc_fill_data : ic_fill_data, e.data);
          check_output("ret_done", dc_fill_vld ? dc_done : ic_done, e.idx == 3'd7);
        end
      end else begin
        check_output("stray_done", {ic_done, dc_done}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic exp_order [4];

    rst_n = 1'b0; ic_miss = 0; dc_miss = 0; dc_wr_req = 0;
    ic_addr = '0; dc_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = DW'(i * 40503) ^ 16'h5A5A;
    for (int i = 0; i < LAT; i++) begin
      rd_vld_pipe[i] = 1'b0;
      rd_addr_pipe[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_mem_en", mem_en, 0);
    check_output("rst_mem_wr", mem_wr, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_busy", {ic_busy, dc_busy}, 0);
    check_output("rst_vld", {ic_fill_vld, dc_fill_vld}, 0);
    check_output("rst_ack", dc_wr_ack, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // I fill with exact cycle timing
    $display("[TB] I fill timing");
    ic_addr = 16'h1236; ic_miss = 1;
    push_fill(0, 16'h1236);
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      check_output($sformatf("t1_mem_en_c%0d", n), mem_en, n <= 8);
      check_output($sformatf("t1_vld_c%0d", n), ic_fill_vld, n >= 5 && n <= 12);
      check_output($sformatf("t1_done_c%0d", n), ic_done, n == 12);
      if (n <= 12) check_output("t1_busy", ic_busy, 1);
      if (n == 12) ic_miss = 0;
    end

    // Conflict: D wins, I granted right after dc_done
    $display("[TB] conflict");
    dc_addr = 16'h4568; ic_addr = 16'h2004; dc_miss = 1; ic_miss = 1;
    push_fill(1, 16'h4568);
    push_fill(0, 16'h2004);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      check_output("t2_ic_busy", ic_busy, 1);
    end while (!dc_done && cyc < 60);
    check_output("t2_dc_done", dc_done, 1);
    dc_miss = 0;
    @(negedge clk);
    check_output("t2_gap_en", mem_en, 0);
    check_output("t2_gap_busy", ic_busy, 1);
    @(negedge clk);
    check_output("t2_i_grant_en", mem_en, 1);
    check_output("t2_i_grant_addr", mem_addr, 16'h2000);
    wait_done(0, "t2_ic_done");
    ic_miss = 0;
    @(negedge clk);

    // Store raised during an I fill waits, then beats a pending D miss
    $display("[TB] store priority");
    ic_addr = 16'h3000; ic_miss = 1;
    push_fill(0, 16'h3000);
    @(negedge clk);
    dc_wr_addr = 16'h3010; dc_wr_data = 16'hBEEF; dc_wr_req = 1;
    dc_addr = 16'h5002; dc_miss = 1;
    push_fill(1, 16'h5002);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      check_output("t3_no_wr", mem_wr, 0);
      check_output("t3_dc_busy", dc_busy, 1);
    end while (!ic_done && cyc < 60);
    check_output("t3_ic_done", ic_done, 1);
    ic_miss = 0;
    @(negedge clk);
    check_output("t3_gap_en", mem_en, 0);
    @(negedge clk);
    check_output("t3_wr_en", {mem_en, mem_wr}, 2'b11);
    check_output("t3_wr_addr", mem_addr, 16'h3010);
    check_output("t3_wr_data", mem_data_in, 16'hBEEF);
    check_output("t3_ack", dc_wr_ack, 1);
    dc_wr_req = 0;
    @(negedge clk);
    check_output("t3_ack_pulse", dc_wr_ack, 0);
    @(negedge clk);
    check_output("t3_d_grant", {mem_en, mem_wr}, 2'b10);
    wait_done(1, "t3_dc_done");
    dc_miss = 0;
    @(negedge clk);
    ic_addr = 16'h3010; ic_miss = 1;
    push_fill(0, 16'h3010);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ic_fill_vld && cyc < 20);
    check_output("t3_store_readback", ic_fill_data, 16'hBEEF);
    wait_done(0, "t3_rb_done");
    ic_miss = 0;
    @(negedge clk);

    // Reset in the middle of a D fill
    $display("[TB] reset mid-fill");
    dc_addr = 16'h6000; dc_miss = 1;
    push_fill(1, 16'h6000);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!(dc_fill_vld && dc_fill_idx == 3'd3) && cyc < 40);
    check_output("t4_at_idx3", dc_fill_vld && dc_fill_idx == 3'd3, 1);
    rst_n = 1'b0; dc_miss = 0;
    #1;
    check_output("t4_rst_vld", {ic_fill_vld, dc_fill_vld, dc_done}, 0);
    check_output("t4_rst_data", dc_fill_data, 0);
    check_output("t4_rst_idx", dc_fill_idx, 0);
    check_output("t4_rst_mem", {mem_en, mem_wr, mem_addr}, 0);
    check_output("t4_rst_busy", {ic_busy, dc_busy}, 0);
    exp_ret_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check_output("t4_quiet_vld", {ic_fill_vld, dc_fill_vld}, 0);
    end
    ic_addr = 16'h7000; ic_miss = 1;
    push_fill(0, 16'h7000);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      check_output($sformatf("t4_regrant_vld_c%0d", n), ic_fill_vld, n == 5);
    end
    wait_done(0, "t4_ic_done");
    ic_miss = 0;

    // Random stores and fills against the reference memory
    $display("[TB] random traffic");
    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      ra = AW'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          rd = DW'($urandom);
          dc_wr_addr = ra; dc_wr_data = rd; dc_wr_req = 1;
          cyc = 0;
          do begin
            @(negedge clk);
            cyc++;
          end while (!dc_wr_ack && cyc < 10);
          check_output("rnd_ack", dc_wr_ack, 1);
          check_output("rnd_wr_addr", mem_addr, ra);
          check_output("rnd_wr_data", mem_data_in, rd);
          dc_wr_req = 0;
        end
        1: begin
          dc_addr = ra; dc_miss = 1;
          push_fill(1, ra);
          wait_done(1, "rnd_dc_done");
          dc_miss = 0;
        end
        default: begin
          ic_addr = ra; ic_miss = 1;
          push_fill(0, ra);
          wait_done(0, "rnd_ic_done");
          ic_miss = 0;
        end
      endcase
    end

    // Grant order with both misses held across four fills
    $display("[TB] grant order");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    dc_addr = 16'h8000; ic_addr = 16'h9000;
    for (int f = 0; f < 4; f++) push_fill(exp_order[f], exp_order[f] ? 16'h8000 : 16'h9000);
    dc_miss = 1; ic_miss = 1;
    for (int f = 0; f < 4; f++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!(ic_done || dc_done) && cyc < 60);
      check_output($sformatf("t6_order_%0d", f), dc_done ? 32'd1 : (ic_done ? 32'd0 : 32'd2), exp_order[f]);
      if (f == 3) begin
        dc_miss = 0;
        ic_miss = 0;
      end
    end

    repeat (10) @(negedge clk);
    check_output("end_ret_queue", exp_ret_q.size(), 0);
    check_output("end_addr_queue", exp_addr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
